btn_sw_io_port: RTL and testbench
=================================

// Module: btn_sw_io_port
// PURPOSE
//  Memory-mapped input port feeding the Hack Computer data bus from DE0 buttons/switches.
//  Synchronises switches; debounces buttons; latches press events until CPU clears them.
//  Sits upstream of Computer: CPU reads via addressM/inM, clears events via writeM/outM.
// PARAMETERS
//  BASE_ADDR   16'h6000  word address of STATUS reg; EVENT reg at BASE_ADDR+1
//  DB_CYCLES   500000    stable-input cycles before a button level is accepted (10 ms @ 50 MHz)
//  RPT_DELAY   25000000  held cycles before first auto-repeat (only with BTN_AUTOREPEAT_EN)
//  RPT_PERIOD  10000000  cycles between subsequent repeats (only with BTN_AUTOREPEAT_EN)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  btn_n      in   3   raw DE0 push buttons, active-low, asynchronous
//  sw         in   10  raw DE0 slide switches, asynchronous
//  addressM   in   16  CPU data address
//  writeM     in   1   CPU write strobe, one cycle per store
//  outM       in   16  CPU write data
//  rd_data    out  16  read data for inM mux; 0 when address not decoded
//  hit        out  1   addressM is BASE_ADDR or BASE_ADDR+1 (drives inM mux select)
//  btn_state  out  3   debounced button levels, 1 = pressed (for LEDs)
// BEHAVIOUR
//  One clock; reset is asynchronous and active-high: all flops, sync stages, counters, FSMs clear.
//  Reset values: rd_data=0 (comb. from cleared regs), btn_state=0, EVENT=0, hit comb.
//  Sync: btn_n and sw each pass 2 flops; input-to-sync latency 2 cycles.
//  Debounce FSM per button: IDLE -> PRESS_WAIT on sync level=1; PRESS_WAIT counts to
//   DB_CYCLES-1 -> PRESSED (btn_state=1, one-cycle press pulse); any bounce to 0 -> IDLE, count=0.
//   PRESSED -> RELEASE_WAIT on level=0; RELEASE_WAIT counts DB_CYCLES-1 -> IDLE (btn_state=0);
//   bounce to 1 -> PRESSED. Counter width $clog2(DB_CYCLES+1); saturates, never wraps.
//  STATUS (BASE_ADDR, RO): {3'b0, btn_state[2:0], sw_sync[9:0]}; writes ignored.
//  EVENT (BASE_ADDR+1): {13'b0, evt[2:0]}; press pulse sets evt[i]; write with outM[i]=1 clears
//   evt[i] (W1C); outM[15:3] ignored. Set and clear in same cycle: set wins (bit stays 1).
//  rd_data combinational from addressM (zero-latency, matches Hack single-cycle memory read).
//  Second press before clear: evt stays 1, no counting. Reset mid-debounce: FSM to IDLE, press lost.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined: in PRESSED, hold counter emits extra press pulse after RPT_DELAY,
//   then every RPT_PERIOD while held; counter clears on leaving PRESSED.
//  Not defined: exactly one press pulse per debounced press; RPT_* params unused, no repeat logic.
// STRUCTURE
//  Package hw_io_pkg: IO_STATUS_OFS=0, IO_EVENT_OFS=1, NUM_BTN=3, NUM_SW=10,
//   typedef enum logic[1:0] {DB_IDLE, DB_PRESS_WAIT, DB_PRESSED, DB_RELEASE_WAIT} db_state_t.
//  Sub-module btn_debounce (sync + FSM + optional repeat), instantiated NUM_BTN times;
//   top holds switch sync, address decode, EVENT register.
// TESTING (bench uses DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8)
//  Reset then read BASE_ADDR, sw=10'h2A5 -> rd_data=16'h02A5 after 2 cycles, hit=1; addr 6002 -> 0, hit=0.
//  btn_n[0] low, held 10 cycles -> btn_state[0]=1 at 2+4 cycles; read BASE+1 -> 16'h0001.
//  btn_n[1] toggles every 2 cycles for 20 cycles, then high -> btn_state/evt stay 0.
//  evt=3'b011; write BASE+1 outM=16'h0001 -> evt=3'b010; write concurrent with new press[1] -> bit1 stays 1.
//  Assert reset during PRESS_WAIT -> btn_state=0, EVENT=0 immediately, no press after deassert unless re-held.
//  BTN_AUTOREPEAT_EN: hold btn2 60 cycles, clear evt after each pulse -> pulses at press, +20, +28, +36...

Source files
------------

// File: rtl/hw_io_pkg.sv
// Shared constants and types for the button/switch memory-mapped input port.
package hw_io_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [15:0] IO_STATUS_OFS = 16'd0;
  localparam logic [15:0] IO_EVENT_OFS  = 16'd1;

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned NUM_SW  = 10;

  // Per-button debounce state
  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, debounce FSM and press pulse.
// Optional auto-repeat while held is built when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
  import hw_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 500000,
  parameter int unsigned RPT_DELAY  = 25000000,
  parameter int unsigned RPT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_state,
  output logic press
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DB_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  logic [1:0]      sync_q;
  logic            level;
  db_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_press;

  // Two-stage synchroniser; inverts so 1 means pressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ~btn_n};
    end
  end

  assign level = sync_q[1];

  // Debounce next-state: entering a wait state counts the first stable sample
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    db_press = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (level) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = CntW'(1);
        end
      end
      DB_PRESS_WAIT: begin
        if (!level) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CntDone) begin
          state_d  = DB_PRESSED;
          cnt_d    = '0;
          db_press = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DB_PRESSED: begin
        if (!level) begin
          state_d = DB_RELEASE_WAIT;
          cnt_d   = CntW'(1);
        end
      end
      DB_RELEASE_WAIT: begin
        if (level) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CntDone) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce state and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_state = (state_q == DB_PRESSED) || (state_q == DB_RELEASE_WAIT);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RptMax = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_q;
  logic            rpt_period_q;  // first repeat already emitted
  logic            rpt_fire;

  // Repeat fires after RPT_DELAY held cycles, then every RPT_PERIOD
  always_comb begin
    rpt_fire = 1'b0;
    if (state_q == DB_PRESSED) begin
      if (rpt_period_q) begin
        rpt_fire = (rpt_q == RptW'(RPT_PERIOD - 1));
      end else begin
        rpt_fire = (rpt_q == RptW'(RPT_DELAY - 1));
      end
    end
  end

  // Hold counter only runs while stably pressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q        <= '0;
      rpt_period_q <= 1'b0;
    end else if (state_q != DB_PRESSED) begin
      rpt_q        <= '0;
      rpt_period_q <= 1'b0;
    end else if (rpt_fire) begin
      rpt_q        <= '0;
      rpt_period_q <= 1'b1;
    end else begin
      rpt_q <= rpt_q + RptW'(1);
    end
  end

  assign press = db_press | rpt_fire;
`else
  logic unused_rpt;
  assign unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
  assign press      = db_press;
`endif

endmodule

// File: rtl/btn_sw_io_port.sv
// Memory-mapped input port for the Hack data bus: STATUS (buttons/switches) and
// EVENT (W1C latched presses). Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_sw_io_port
  import hw_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h6000,
  parameter int unsigned DB_CYCLES  = 500000,
  parameter int unsigned RPT_DELAY  = 25000000,
  parameter int unsigned RPT_PERIOD = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [15:0]        addressM,
  input  logic               writeM,
  input  logic [15:0]        outM,
  output logic [15:0]        rd_data,
  output logic               hit,
  output logic [NUM_BTN-1:0] btn_state
);

  localparam logic [15:0] StatusAddr = BASE_ADDR + IO_STATUS_OFS;
  localparam logic [15:0] EventAddr  = BASE_ADDR + IO_EVENT_OFS;

  logic [NUM_BTN-1:0] press;
  logic [NUM_SW-1:0]  sw_meta_q, sw_sync_q;
  logic [NUM_BTN-1:0] evt_q, evt_d, evt_clr;
  logic               status_sel, event_sel;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_btn_debounce (
      .clk      (clk),
      .reset    (reset),
      .btn_n    (btn_n[i]),
      .btn_state(btn_state[i]),
      .press    (press[i])
    );
  end

  // Two-stage switch synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign status_sel = (addressM == StatusAddr);
  assign event_sel  = (addressM == EventAddr);
  assign hit        = status_sel | event_sel;

  // W1C clear, with a same-cycle press taking priority
  always_comb begin
    evt_clr = '0;
    if (writeM && event_sel) begin
      evt_clr = outM[NUM_BTN-1:0];
    end
    evt_d = (evt_q & ~evt_clr) | press;
  end

  // Latched press events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  logic unused_outm;
  assign unused_outm = ^outM[15:NUM_BTN];

  // Zero-latency read mux, as the CPU expects single-cycle memory reads
  always_comb begin
    rd_data = '0;
    if (status_sel) begin
      rd_data = {3'b000, btn_state, sw_sync_q};
    end else if (event_sel) begin
      rd_data = {13'b0, evt_q};
    end
  end

endmodule

// File: tb/tb_btn_sw_io_port.sv
// Self-checking bench for btn_sw_io_port. Define BTN_AUTOREPEAT_EN to exercise repeat.
module tb_btn_sw_io_port;

  localparam logic [15:0] BASE = 16'h6000;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic        clk;
  logic        reset;
  logic [2:0]  btn_n;
  logic [9:0]  sw;
  logic [15:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] rd_data;
  logic        hit;
  logic [2:0]  btn_state;

  int checks = 0;
  int errors = 0;

  btn_sw_io_port #(
    .BASE_ADDR (BASE),
    .DB_CYCLES (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .sw       (sw),
    .addressM (addressM),
    .writeM   (writeM),
    .outM     (outM),
    .rd_data  (rd_data),
    .hit      (hit),
    .btn_state(btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a button's debounced value flips once the synchronised
  // level has disagreed with it for DB consecutive samples.
  logic [2:0] m_b0, m_b1, m_deb, m_evt;
  logic [9:0] m_sw0, m_sw1;
  int         m_run  [3];
  int         m_hold [3];

  function automatic logic [2:0] model_set();
    logic [2:0] s;
    int h;
    s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (m_b1[i] && !m_deb[i] && (m_run[i] + 1 >= DB)) s[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      if (m_deb[i] && m_run[i] == 0) begin
        h = m_hold[i] + 1;
        if (h == RD || (h > RD && ((h - RD) % RP) == 0)) s[i] = 1'b1;
      end
`endif
    end
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_b0  <= '0;
      m_b1  <= '0;
      m_deb <= '0;
      m_evt <= '0;
      m_sw0 <= '0;
      m_sw1 <= '0;
      for (int i = 0; i < 3; i++) begin
        m_run[i]  <= 0;
        m_hold[i] <= 0;
      end
    end else begin
      m_b0  <= ~btn_n;
      m_b1  <= m_b0;
      m_sw0 <= sw;
      m_sw1 <= m_sw0;
      m_evt <= (m_evt & ~((writeM && addressM == BASE + 16'd1) ? outM[2:0] : 3'b000))
               | model_set();
      for (int i = 0; i < 3; i++) begin
        if (m_b1[i] != m_deb[i]) begin
          if (m_run[i] + 1 >= DB) begin
            m_deb[i] <= m_b1[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
        if (m_deb[i] && m_run[i] == 0) m_hold[i] <= m_hold[i] + 1;
        else m_hold[i] <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    btn_n    = 3'b111;
    sw       = 10'h000;
    addressM = BASE;
    writeM   = 1'b0;
    outM     = 16'h0000;
    tick();
    tick();
    checks++;
    if (btn_state !== 3'b000) begin
      errors++;
      $display("FAIL reset_btn_state got %b want 000", btn_state);
    end
    checks++;
    if (rd_data !== 16'h0000 || hit !== 1'b1) begin
      errors++;
      $display("FAIL reset_status got %h hit %b want 0000 hit 1", rd_data, hit);
    end
    addressM = BASE + 16'd1;
    #1;
    checks++;
    if (rd_data !== 16'h0000 || hit !== 1'b1) begin
      errors++;
      $display("FAIL reset_event got %h hit %b want 0000 hit 1", rd_data, hit);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_switch();
    logic [9:0] v;
    sw       = 10'h2A5;
    addressM = BASE;
    tick();
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL sw_latency1 got %h want 0000", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 16'h02A5 || hit !== 1'b1) begin
      errors++;
      $display("FAIL sw_status got %h hit %b want 02a5 hit 1", rd_data, hit);
    end
    addressM = BASE + 16'd2;
    #1;
    checks++;
    if (rd_data !== 16'h0000 || hit !== 1'b0) begin
      errors++;
      $display("FAIL undecoded got %h hit %b want 0000 hit 0", rd_data, hit);
    end
    for (int k = 0; k < 6; k++) begin
      v  = 10'($urandom);
      sw = v;
      tick();
      tick();
      addressM = BASE;
      #1;
      checks++;
      if (rd_data !== {6'b0, v}) begin
        errors++;
        $display("FAIL sw_random got %h want %h", rd_data, {6'b0, v});
      end
      addressM = 16'h1234;
      #1;
      checks++;
      if (rd_data !== 16'h0000 || hit !== 1'b0) begin
        errors++;
        $display("FAIL far_addr got %h hit %b want 0000 hit 0", rd_data, hit);
      end
    end
  endtask

  task automatic test_press();
    addressM = BASE;
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (btn_state[0] !== (k >= 2 + DB)) begin
        errors++;
        $display("FAIL press_timing cycle %0d got %b want %b", k, btn_state[0], k >= 2 + DB);
      end
    end
    addressM = BASE + 16'd1;
    #1;
    checks++;
    if (rd_data !== 16'h0001) begin
      errors++;
      $display("FAIL press_event got %h want 0001", rd_data);
    end
    btn_n[0] = 1'b1;
    repeat (8) tick();
    checks++;
    if (btn_state !== 3'b000 || rd_data !== 16'h0001) begin
      errors++;
      $display("FAIL release got %b evt %h want 000 evt 0001", btn_state, rd_data);
    end
    writeM = 1'b1;
    outM   = 16'h0001;
    tick();
    writeM = 1'b0;
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL clear_evt0 got %h want 0000", rd_data);
    end
  endtask

  task automatic test_bounce();
    addressM = BASE + 16'd1;
    for (int k = 0; k < 20; k++) begin
      btn_n[1] = ((k / 2) % 2) != 0;
      tick();
      checks++;
      if (btn_state[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_state cycle %0d got %b want 0", k, btn_state[1]);
      end
    end
    btn_n[1] = 1'b1;
    repeat (6) tick();
    checks++;
    if (rd_data !== 16'h0000 || btn_state !== 3'b000) begin
      errors++;
      $display("FAIL bounce_evt got %h state %b want 0000 000", rd_data, btn_state);
    end
  endtask

  task automatic test_w1c();
    addressM = BASE + 16'd1;
    btn_n    = 3'b100;
    repeat (8) tick();
    btn_n = 3'b111;
    repeat (8) tick();
    checks++;
    if (rd_data !== 16'h0003) begin
      errors++;
      $display("FAIL w1c_setup got %h want 0003", rd_data);
    end
    writeM = 1'b1;
    outM   = 16'h0001;
    tick();
    writeM = 1'b0;
    checks++;
    if (rd_data !== 16'h0002) begin
      errors++;
      $display("FAIL w1c_bit0 got %h want 0002", rd_data);
    end
    writeM = 1'b1;
    outM   = 16'hFFF8;
    tick();
    writeM = 1'b0;
    checks++;
    if (rd_data !== 16'h0002) begin
      errors++;
      $display("FAIL w1c_upper_ignored got %h want 0002", rd_data);
    end
    addressM = BASE;
    outM     = 16'hFFFF;
    writeM   = 1'b1;
    tick();
    writeM   = 1'b0;
    addressM = BASE + 16'd1;
    #1;
    checks++;
    if (rd_data !== 16'h0002) begin
      errors++;
      $display("FAIL status_write_ignored got %h want 0002", rd_data);
    end
    // Clear lands on the same edge as a new press of button 1
    btn_n[1] = 1'b0;
    repeat (2 + DB - 1) tick();
    writeM = 1'b1;
    outM   = 16'h0002;
    tick();
    writeM = 1'b0;
    checks++;
    if (rd_data !== 16'h0002 || btn_state[1] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got %h state %b want 0002 1", rd_data, btn_state[1]);
    end
    btn_n[1] = 1'b1;
    repeat (8) tick();
    writeM = 1'b1;
    outM   = 16'h0002;
    tick();
    writeM = 1'b0;
    checks++;
    if (rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL w1c_bit1 got %h want 0000", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    addressM = BASE + 16'd1;
    btn_n[0] = 1'b0;
    repeat (8) tick();
    btn_n[0] = 1'b1;
    repeat (8) tick();
    btn_n[2] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (btn_state !== 3'b000 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid got %b evt %h want 000 0000", btn_state, rd_data);
    end
    btn_n[2] = 1'b1;
    tick();
    reset = 1'b0;
    repeat (12) tick();
    checks++;
    if (btn_state !== 3'b000 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL press_lost got %b evt %h want 000 0000", btn_state, rd_data);
    end
    btn_n[2] = 1'b0;
    for (int k = 1; k <= 2 + DB; k++) begin
      tick();
      checks++;
      if (btn_state[2] !== (k == 2 + DB)) begin
        errors++;
        $display("FAIL rehold cycle %0d got %b want %b", k, btn_state[2], k == 2 + DB);
      end
    end
    btn_n[2] = 1'b1;
    repeat (8) tick();
    writeM = 1'b1;
    outM   = 16'h0007;
    tick();
    writeM = 1'b0;
  endtask

  task automatic test_hold();
    int got[$];
    int exp_q[$];
`ifdef BTN_AUTOREPEAT_EN
    exp_q = '{6, 26, 34, 42, 50, 58};
`else
    exp_q = '{6};
`endif
    addressM = BASE + 16'd1;
    writeM   = 1'b1;
    outM     = 16'h0007;
    tick();
    writeM   = 1'b0;
    btn_n[2] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (rd_data[2]) begin
        got.push_back(k);
        writeM = 1'b1;
        outM   = 16'h0004;
      end else begin
        writeM = 1'b0;
      end
    end
    writeM = 1'b0;
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL hold_pulse_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] != exp_q[i]) begin
        errors++;
        $display("FAIL hold_pulse_time idx %0d got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
    btn_n = 3'b111;
    repeat (10) tick();
    writeM = 1'b1;
    outM   = 16'h0007;
    tick();
    writeM = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_rd;
    logic        exp_hit;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(7) == 0) btn_n[i] = ~btn_n[i];
      end
      if ($urandom_range(3) == 0) sw = 10'($urandom);
      case ($urandom_range(3))
        0:       addressM = BASE;
        1:       addressM = BASE + 16'd1;
        2:       addressM = BASE + 16'd2;
        default: addressM = 16'($urandom);
      endcase
      writeM = ($urandom_range(3) == 0);
      outM   = 16'($urandom);
      tick();
      exp_hit = (addressM == BASE) || (addressM == BASE + 16'd1);
      if (addressM == BASE) exp_rd = {3'b000, m_deb, m_sw1};
      else if (addressM == BASE + 16'd1) exp_rd = {13'b0, m_evt};
      else exp_rd = 16'h0000;
      checks++;
      if (btn_state !== m_deb) begin
        errors++;
        $display("FAIL rand_btn_state cycle %0d got %b want %b", n, btn_state, m_deb);
      end
      checks++;
      if (hit !== exp_hit || rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rand_read cycle %0d addr %h got %h hit %b want %h hit %b",
                 n, addressM, rd_data, hit, exp_rd, exp_hit);
      end
    end
    writeM = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_press();
    test_bounce();
    test_w1c();
    test_reset_mid();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
